// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the core's memory-port arbitration.
//   owner_t : which requester currently holds the memory port
//   state_t : arbiter FSM states
package riscv_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 64;
  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned MEM_STRB_W = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LSU  = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between instruction fetch and the LSU, plus the
// starvation counter that guarantees fetch forward progress.
//   clk, rst_n : clock, asynchronous active-low reset
//   if_req     : fetch request pending
//   lsu_req    : LSU request pending
//   arb_en     : arbiter is in IDLE and may take a decision this cycle
//   winner     : OWN_LSU / OWN_IF, or OWN_NONE when nobody requests
module mem_arb_pick
  import riscv_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   if_req,
  input  logic   lsu_req,
  input  logic   arb_en,
  output owner_t winner
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  // LSU has priority unless fetch has already lost CNT_MAX times in a row.
  always_comb begin
    winner = OWN_NONE;
    if (lsu_req && !(if_req && (starve_cnt == CNT_MAX))) begin
      winner = OWN_LSU;
    end else if (if_req) begin
      winner = OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (arb_en && (winner != OWN_NONE)) begin
      if ((winner == OWN_LSU) && if_req) begin
        starve_cnt <= (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the core's single memory port between instruction fetch (IF) and
// the load/store unit (LSU); one outstanding transaction at a time.
//   clk, rst_n              : clock, asynchronous active-low reset
//   if_req/if_addr          : fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata : fetch accept and one-cycle response
//   lsu_req/we/addr/wdata/wstrb : LSU request, held until lsu_gnt
//   lsu_gnt/lsu_rvalid/lsu_rdata : LSU accept and one-cycle response
//   mem_req/we/addr/wdata/wstrb : request to unified memory
//   mem_gnt/mem_rvalid/mem_rdata : memory accept and response
//   busy                    : a transaction is in progress
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  state_t state, state_n;
  owner_t owner, owner_n;
  owner_t winner;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_req (if_req),
    .lsu_req(lsu_req),
    .arb_en (state == ST_IDLE),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= OWN_NONE;
    end else begin
      state <= state_n;
      owner <= owner_n;
    end
  end

  // Address/data are passed through from the locked owner rather than
  // registered; requesters hold their fields stable until granted.
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    if_gnt     = 1'b0;
    lsu_gnt    = 1'b0;
    if_rvalid  = 1'b0;
    lsu_rvalid = 1'b0;
    if_rdata   = '0;
    lsu_rdata  = '0;
    busy       = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (winner != OWN_NONE) begin
          owner_n = winner;
          state_n = ST_REQ;
        end
      end

      ST_REQ: begin
        mem_req = 1'b1;
        if (owner == OWN_LSU) begin
          mem_we    = lsu_we;
          mem_addr  = lsu_addr;
          mem_wdata = lsu_wdata;
          mem_wstrb = lsu_wstrb;
        end else begin
          mem_addr  = if_addr;
        end
        if (mem_gnt) begin
          if (owner == OWN_LSU) begin
            lsu_gnt = 1'b1;
          end else begin
            if_gnt  = 1'b1;
          end
          state_n = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (mem_rvalid) begin
          if (owner == OWN_LSU) begin
            lsu_rvalid = 1'b1;
            lsu_rdata  = mem_rdata;
          end else begin
            if_rvalid  = 1'b1;
            if_rdata   = mem_rdata;
          end
          owner_n = OWN_NONE;
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
        owner_n = OWN_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model is
// compared against every output on each falling edge, and directed
// scenarios add hand-computed literal expectations.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 64;
  localparam int unsigned DW   = 64;
  localparam int unsigned SW   = DW / 8;
  localparam int          SMAX = 4;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b1;
  logic          if_req     = 1'b0;
  logic [AW-1:0] if_addr    = '0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          lsu_req    = 1'b0;
  logic          lsu_we     = 1'b0;
  logic [AW-1:0] lsu_addr   = '0;
  logic [DW-1:0] lsu_wdata  = '0;
  logic [SW-1:0] lsu_wstrb  = '0;
  logic          lsu_gnt;
  logic          lsu_rvalid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_gnt    = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata  = '0;
  logic          busy;

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .lsu_req   (lsu_req),
    .lsu_we    (lsu_we),
    .lsu_addr  (lsu_addr),
    .lsu_wdata (lsu_wdata),
    .lsu_wstrb (lsu_wstrb),
    .lsu_gnt   (lsu_gnt),
    .lsu_rvalid(lsu_rvalid),
    .lsu_rdata (lsu_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who holds the port, whether memory accepted it,
  // and how many consecutive times fetch has lost arbitration.
  int            m_owner   = 0;   // 0 none, 1 fetch, 2 LSU
  bit            m_granted = 1'b0;
  int            m_starve  = 0;
  int            win;
  logic          e_req, e_we, e_ig, e_lg, e_ir, e_lr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_ird, e_lrd;
  logic [SW-1:0] e_ws;
  bit            log_en = 1'b0;
  int            glog[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner   = 0;
      m_granted = 1'b0;
      m_starve  = 0;
    end
    e_req  = (m_owner != 0) && !m_granted;
    e_we   = e_req && (m_owner == 2) && lsu_we;
    e_addr = !e_req ? '0 : ((m_owner == 2) ? lsu_addr : if_addr);
    e_wd   = (e_req && (m_owner == 2)) ? lsu_wdata : '0;
    e_ws   = (e_req && (m_owner == 2)) ? lsu_wstrb : '0;
    e_ig   = e_req && (m_owner == 1) && mem_gnt;
    e_lg   = e_req && (m_owner == 2) && mem_gnt;
    e_ir   = m_granted && (m_owner == 1) && mem_rvalid;
    e_lr   = m_granted && (m_owner == 2) && mem_rvalid;
    e_ird  = e_ir ? mem_rdata : '0;
    e_lrd  = e_lr ? mem_rdata : '0;

    check("model_ctrl", {57'd0, busy, mem_req, mem_we, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid},
          {57'd0, (m_owner != 0), e_req, e_we, e_ig, e_lg, e_ir, e_lr});
    check("model_mem_addr", mem_addr, e_addr);
    check("model_mem_wdata", mem_wdata, e_wd);
    check("model_mem_wstrb", 64'(mem_wstrb), 64'(e_ws));
    check("model_if_rdata", if_rdata, e_ird);
    check("model_lsu_rdata", lsu_rdata, e_lrd);

    if (log_en && if_gnt)  glog.push_back(1);
    if (log_en && lsu_gnt) glog.push_back(2);

    if (rst_n) begin
      if (m_owner == 0) begin
        if (if_req || lsu_req) begin
          win = (lsu_req && !(if_req && (m_starve == SMAX))) ? 2 : 1;
          if ((win == 2) && if_req) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
          else                      m_starve = 0;
          m_owner   = win;
          m_granted = 1'b0;
        end
      end else if (!m_granted) begin
        if (mem_gnt) m_granted = 1'b1;
      end else if (mem_rvalid) begin
        m_owner   = 0;
        m_granted = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Captures from the latest serve() call.
  logic          c_ig, c_lg, c_we, c_req, c_ir, c_lr;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wd, c_ird, c_lrd;
  logic [SW-1:0] c_ws;

  // Well-behaved memory for one transaction starting in an IDLE cycle:
  // accept immediately, respond the next cycle. With drop=1 the granted
  // requester withdraws its request after the grant.
  task automatic serve(input logic [63:0] rd, input bit drop);
    tick();
    mem_gnt = 1'b1; mem_rvalid = 1'b0;
    #1;
    c_req = mem_req; c_ig = if_gnt; c_lg = lsu_gnt; c_we = mem_we;
    c_addr = mem_addr; c_wd = mem_wdata; c_ws = mem_wstrb;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    if (drop && c_ig) if_req = 1'b0;
    if (drop && c_lg) lsu_req = 1'b0;
    #1;
    c_ir = if_rvalid; c_lr = lsu_rvalid; c_ird = if_rdata; c_lrd = lsu_rdata;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_order[10];
    exp_order = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    #1 rst_n = 1'b0;
    tick();
    tick();
    check("reset_ctrl", {57'd0, busy, mem_req, mem_we, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid}, 64'd0);
    rst_n = 1'b1;

    // Single fetch: cycle 0 request, gnt in cycle 1, response in cycle 3.
    tick();
    if_req = 1'b1; if_addr = 64'h0;
    #1 check("if_c0_busy", busy, 0);
    check("if_c0_mem_req", mem_req, 0);
    tick();
    mem_gnt = 1'b1;
    #1 check("if_c1_mem_req", mem_req, 1);
    check("if_c1_mem_addr", mem_addr, 64'h0);
    check("if_c1_mem_we", mem_we, 0);
    check("if_c1_if_gnt", if_gnt, 1);
    check("if_c1_busy", busy, 1);
    tick();
    if_req = 1'b0; mem_gnt = 1'b0;
    #1 check("if_c2_busy", busy, 1);
    check("if_c2_mem_req", mem_req, 0);
    check("if_c2_if_rvalid", if_rvalid, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'h13;
    #1 check("if_c3_if_rvalid", if_rvalid, 1);
    check("if_c3_if_rdata", if_rdata, 64'h13);
    check("if_c3_lsu_rvalid", lsu_rvalid, 0);
    check("if_c3_busy", busy, 1);
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1 check("if_c4_busy", busy, 0);

    // Reset while waiting for a load response.
    tick();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h80;
    tick();
    mem_gnt = 1'b1;
    #1 check("rst_lsu_gnt", lsu_gnt, 1);
    check("rst_mem_addr", mem_addr, 64'h80);
    tick();
    lsu_req = 1'b0; mem_gnt = 1'b0;
    #1 check("rst_wait_busy", busy, 1);
    rst_n = 1'b0;
    #1 check("rst_now_ctrl", {57'd0, busy, mem_req, mem_we, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid}, 64'd0);
    check("rst_now_addr", mem_addr, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
    #1 check("rst_after_lsu_rvalid", lsu_rvalid, 0);
    check("rst_after_busy", busy, 0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1 check("rst_after2_lsu_rvalid", lsu_rvalid, 0);
    check("rst_after2_busy", busy, 0);

    // Simultaneous requests: LSU store first, then the fetch.
    tick();
    if_req = 1'b1; if_addr = 64'h200;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h100; lsu_wdata = 64'hDEAD; lsu_wstrb = 8'h0F;
    serve(64'h5555, 1'b1);
    check("sim_lsu_gnt", c_lg, 1);
    check("sim_if_gnt_first", c_ig, 0);
    check("sim_we", c_we, 1);
    check("sim_wstrb", 64'(c_ws), 64'h0F);
    check("sim_addr", c_addr, 64'h100);
    check("sim_wdata", c_wd, 64'hDEAD);
    check("sim_lsu_rvalid", c_lr, 1);
    check("sim_if_rvalid_first", c_ir, 0);
    lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0;
    serve(64'h1234, 1'b1);
    check("sim_if_gnt", c_ig, 1);
    check("sim_if_addr", c_addr, 64'h200);
    check("sim_if_we", c_we, 0);
    check("sim_if_wstrb", 64'(c_ws), 64'h0);
    check("sim_if_rvalid", c_ir, 1);
    check("sim_if_rdata", c_ird, 64'h1234);

    // Starvation: both requesters held continuously.
    pulse_reset();
    if_req = 1'b1; if_addr = 64'h600;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h500;
    glog.delete();
    log_en = 1'b1;
    for (int i = 0; i < 10; i++) serve(64'(i + 1), 1'b0);
    log_en = 1'b0;
    if_req = 1'b0; lsu_req = 1'b0;
    check("starve_count", 64'(glog.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("starve_order_%0d", i), (i < glog.size()) ? 64'(glog[i]) : 64'd0, 64'(exp_order[i]));
    end
    tick();

    // Memory stall with fetch owning the port while LSU arrives.
    tick();
    if_req = 1'b1; if_addr = 64'h300;
    tick();
    mem_gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h400;
      end
      #1 check($sformatf("stall_mem_req_%0d", k), mem_req, 1);
      check($sformatf("stall_mem_addr_%0d", k), mem_addr, 64'h300);
      check($sformatf("stall_lsu_gnt_%0d", k), lsu_gnt, 0);
      tick();
    end
    mem_gnt = 1'b1;
    #1 check("stall_if_gnt", if_gnt, 1);
    check("stall_lsu_gnt_end", lsu_gnt, 0);
    check("stall_addr_end", mem_addr, 64'h300);
    tick();
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h77;
    #1 check("stall_if_rvalid", if_rvalid, 1);
    check("stall_if_rdata", if_rdata, 64'h77);
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    serve(64'h99, 1'b1);
    check("stall_lsu_after_gnt", c_lg, 1);
    check("stall_lsu_after_addr", c_addr, 64'h400);
    check("stall_lsu_after_rvalid", c_lr, 1);
    check("stall_lsu_after_rdata", c_lrd, 64'h99);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IF) and the load/store unit (LSU).
- Sits between the datapath's fetch/LSU request interfaces and the unified memory under riscv_top.
- Allows one outstanding transaction at a time.
- LSU has priority, but a starvation counter guarantees IF forward progress.

Parameters:
ADDR_W, 64, address width (RV64)
DATA_W, 64, data width; strobe width is DATA_W/8
STARVE_MAX, 4, consecutive LSU wins with if_req pending before IF is forced to win (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted by memory
if_rvalid  out  1  fetch data valid, one cycle
if_rdata  out  DATA_W  fetch data
lsu_req  in  1  LSU request; held with all lsu_* fields until lsu_gnt
lsu_we  in  1  1 = store, 0 = load
lsu_addr  in  ADDR_W  LSU address
lsu_wdata  in  DATA_W  store data
lsu_wstrb  in  DATA_W/8  store byte enables
lsu_gnt  out  1  LSU request accepted
lsu_rvalid  out  1  load data / store ack valid, one cycle
lsu_rdata  out  DATA_W  load data (don't-care on store ack)
mem_req  out  1  request to memory
mem_we  out  1  write enable
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_wstrb  out  DATA_W/8  byte enables; all-zero for reads and for IF
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  response valid (read data or write ack)
mem_rdata  in  DATA_W  read data
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=NONE, starve_cnt=0.
  - All outputs 0, including mem_req, gnts, rvalids and busy.
  - Reset mid-transaction discards the transaction; no response is delivered.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If either request is high, pick the winner, register it as owner and go to REQ next cycle. mem_req stays 0 in IDLE.
  - Winner rule: LSU if lsu_req and not (if_req and starve_cnt==STARVE_MAX); otherwise IF.
- REQ:
  - mem_req=1. The mem_* fields are taken combinationally from the owner's inputs; IF drives mem_we=0, wstrb=0.
  - The owner is locked; the other requester cannot pre-empt.
  - When mem_gnt=1: assert the owner's gnt the same cycle and go to WAIT.
  - When mem_gnt=0: stay in REQ.
- WAIT:
  - mem_req=0.
  - When mem_rvalid=1: drive the owner's rvalid=1 and rdata=mem_rdata combinationally the same cycle, clear owner, go to IDLE.
  - The non-owner's rvalid is always 0.
- Starvation counter, updated at each IDLE arbitration:
  - LSU wins while if_req=1: starve_cnt += 1, saturating at STARVE_MAX.
  - IF wins, or if_req=0: starve_cnt = 0.
- Minimum transaction: request seen in IDLE (cycle 0), mem_req/gnt in cycle 1, rvalid in cycle 2 at the earliest. Next arbitration is in the cycle after rvalid, so peak throughput is 1 transaction per 3 cycles.
- Ignored inputs:
  - mem_rvalid in IDLE or REQ is ignored (protocol violation; simulation assertion only).
  - mem_gnt outside REQ is ignored.
- A requester dropping req while in REQ as owner is a protocol violation; the arbiter keeps presenting the latched owner's inputs.
- The data path does not register addresses or data; the requester-hold rule guarantees stability.

Decomposition:
- Package riscv_mem_pkg:
  - owner_t enum {NONE, IF, LSU}.
  - state_t enum {IDLE, REQ, WAIT}.
  - ADDR_W/DATA_W defaults, STRB_W = DATA_W/8.
- Sub-module mem_arb_pick: combinational winner select plus the starve_cnt register. Inputs: if_req, lsu_req, arb_en (state==IDLE). Output: winner.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: LSU load 0x80 granted, rst_n pulsed low before rvalid.
  - Required: all outputs 0 immediately; no lsu_rvalid after release; busy=0.
- Single IF fetch:
  - Stimulus: if_req with addr 0x0; mem_gnt in cycle 1; rvalid in cycle 3 with rdata 0x00000013.
  - Required: mem_addr=0x0, mem_we=0, if_gnt in cycle 1, if_rvalid with 0x13 in cycle 3, busy high in cycles 1-3.
- Simultaneous requests:
  - Stimulus: if_req and lsu_req (store addr 0x100, wdata 0xDEAD, wstrb 0x0F) in the same cycle; memory grants at once, rvalid next cycle.
  - Required: LSU served first with mem_we=1, wstrb=0x0F; IF served in the following transaction.
- Starvation:
  - Stimulus: if_req and lsu_req held high continuously, STARVE_MAX=4.
  - Required: grant order LSU, LSU, LSU, LSU, IF, then repeating; starve_cnt returns to 0 after each IF win.
- Memory stall:
  - Stimulus: mem_gnt held low for 5 cycles in REQ while lsu_req rises during that time.
  - Required: mem_req stays high with IF's address throughout; no lsu_gnt until IF completes.
